// File: rtl/directory_controller_pkg.sv
// Shared encodings for the MSI home-node directory: entry states, request,
// command and response codes, and the controller's FSM states.
package dir_pkg;

  typedef enum logic [1:0] {
    DIR_UNCACHED  = 2'b01,
    DIR_SHARED    = 2'b10,
    DIR_EXCLUSIVE = 2'b11
  } dir_state_e;

  typedef enum logic [1:0] {
    REQ_READ_MISS  = 2'b00,
    REQ_WRITE_MISS = 2'b01,
    REQ_UPGRADE    = 2'b10,
    REQ_ILLEGAL    = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    CMD_INV       = 2'b00,
    CMD_FETCH     = 2'b01,
    CMD_FETCH_INV = 2'b10
  } cmd_type_e;

  typedef enum logic [1:0] {
    RESP_DATA_SHARED = 2'b00,
    RESP_DATA_EXCL   = 2'b01,
    RESP_UPGRADE_ACK = 2'b10
  } resp_type_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_CMD      = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RESPOND  = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/directory_entry_array.sv
// Directory storage: per block a 2-bit state and a sharer vector.
// The read address is captured on rd_en; rd_* then follows that entry.
module directory_entry_array
  import dir_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int NUM_BLOCKS = 16,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [1:0]           rd_state,
  output logic [NUM_NODES-1:0] rd_sharers,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [1:0]           wr_state,
  input  logic [NUM_NODES-1:0] wr_sharers
);

  logic [1:0]           state_mem  [NUM_BLOCKS];
  logic [NUM_NODES-1:0] sharer_mem [NUM_BLOCKS];
  logic [ADDR_W-1:0]    rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        state_mem[i]  <= DIR_UNCACHED;
        sharer_mem[i] <= '0;
      end
    end else begin
      if (rd_en) rd_addr_q <= rd_addr;
      if (wr_en) begin
        state_mem[wr_addr]  <= wr_state;
        sharer_mem[wr_addr] <= wr_sharers;
      end
    end
  end

  assign rd_state   = state_mem[rd_addr_q];
  assign rd_sharers = sharer_mem[rd_addr_q];

endmodule

// File: rtl/directory_controller.sv
// MSI home-node directory controller: serialises miss/upgrade requests,
// issues invalidate/fetch commands, collects acks and answers the requester.
module directory_controller
  import dir_pkg::*;
#(
  parameter int NUM_NODES   = 4,
  parameter int NUM_BLOCKS  = 16,
  parameter int ADDR_W      = $clog2(NUM_BLOCKS),
  parameter int NODE_W      = $clog2(NUM_NODES),
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [NODE_W-1:0]    req_node,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_type,
  output logic [NUM_NODES-1:0] cmd_mask,
  output logic [ADDR_W-1:0]    cmd_addr,
  input  logic [NUM_NODES-1:0] ack_vec,
  output logic                 resp_valid,
  output logic [1:0]           resp_type,
  output logic [NODE_W-1:0]    resp_node,
  output logic [ADDR_W-1:0]    resp_addr,
  output logic                 mem_wb,
  output logic                 err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // cmd_valid / resp_valid / mem_wb / err are single-cycle pulses with no back-pressure.

  fsm_state_e fsm_q, fsm_d;

  logic [1:0]           req_type_q;
  logic [NODE_W-1:0]    req_node_q;
  logic [ADDR_W-1:0]    req_addr_q;
  logic [1:0]           cmd_type_q;
  logic [NUM_NODES-1:0] cmd_mask_q;
  logic [1:0]           resp_type_q;
  logic                 wb_q;
  logic [1:0]           new_state_q;
  logic [NUM_NODES-1:0] new_sharers_q;
  logic [NUM_NODES-1:0] pending_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [1:0]           rd_state;
  logic [NUM_NODES-1:0] rd_sharers;

  logic [NUM_NODES-1:0] req_bit;
  logic                 is_write;
  logic                 illegal;
  logic [1:0]           dec_cmd_type;
  logic [NUM_NODES-1:0] dec_mask;
  logic [1:0]           dec_state;
  logic [NUM_NODES-1:0] dec_sharers;
  logic [1:0]           dec_resp;
  logic                 dec_wb;
  logic [NUM_NODES-1:0] pending_after;
  logic                 timeout_hit;

  directory_entry_array #(
    .NUM_NODES (NUM_NODES),
    .NUM_BLOCKS(NUM_BLOCKS),
    .ADDR_W    (ADDR_W)
  ) u_entries (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (req_valid && req_ready),
    .rd_addr   (req_addr),
    .rd_state  (rd_state),
    .rd_sharers(rd_sharers),
    .wr_en     (resp_valid),
    .wr_addr   (req_addr_q),
    .wr_state  (new_state_q),
    .wr_sharers(new_sharers_q)
  );

  assign req_bit  = NUM_NODES'(1) << req_node_q;
  assign is_write = (req_type_q != REQ_READ_MISS);
  assign illegal  = (req_type_q == REQ_ILLEGAL);

  // Protocol decision from the looked-up entry; captured at the end of LOOKUP.
  always_comb begin
    dec_cmd_type = CMD_INV;
    dec_mask     = '0;
    dec_state    = DIR_SHARED;
    dec_sharers  = req_bit;
    dec_resp     = RESP_DATA_SHARED;
    dec_wb       = 1'b0;
    case (rd_state)
      DIR_SHARED: begin
        if (!is_write) begin
          dec_sharers = rd_sharers | req_bit;
        end else begin
          dec_cmd_type = CMD_INV;
          dec_mask     = rd_sharers & ~req_bit;
          dec_state    = DIR_EXCLUSIVE;
          // An upgrade from a node no longer in the sharer set is stale: give it data.
          dec_resp     = (req_type_q == REQ_UPGRADE && (rd_sharers & req_bit) != '0)
                         ? RESP_UPGRADE_ACK : RESP_DATA_EXCL;
        end
      end
      DIR_EXCLUSIVE: begin
        if ((rd_sharers & req_bit) != '0) begin
          if (is_write) begin
            dec_state = DIR_EXCLUSIVE;
            dec_resp  = (req_type_q == REQ_UPGRADE) ? RESP_UPGRADE_ACK : RESP_DATA_EXCL;
          end
        end else if (!is_write) begin
          dec_cmd_type = CMD_FETCH;
          dec_mask     = rd_sharers;
          dec_sharers  = rd_sharers | req_bit;
          dec_wb       = 1'b1;
        end else begin
          dec_cmd_type = CMD_FETCH_INV;
          dec_mask     = rd_sharers;
          dec_state    = DIR_EXCLUSIVE;
          dec_resp     = RESP_DATA_EXCL;
          dec_wb       = 1'b1;
        end
      end
      default: begin
        if (is_write) begin
          dec_state = DIR_EXCLUSIVE;
          dec_resp  = RESP_DATA_EXCL;
        end
      end
    endcase
  end

  assign pending_after = pending_q & ~ack_vec;
  assign timeout_hit   = (fsm_q == S_WAIT_ACK) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1))
                         && (pending_after != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:     if (req_valid) fsm_d = S_LOOKUP;
      S_LOOKUP: begin
        if (illegal)              fsm_d = S_IDLE;
        else if (dec_mask != '0)  fsm_d = S_CMD;
        else                      fsm_d = S_RESPOND;
      end
      S_CMD:      fsm_d = S_WAIT_ACK;
      S_WAIT_ACK: if (pending_after == '0 || timeout_hit) fsm_d = S_RESPOND;
      S_RESPOND:  fsm_d = S_IDLE;
      default:    fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_type_q    <= '0;
      req_node_q    <= '0;
      req_addr_q    <= '0;
      cmd_type_q    <= '0;
      cmd_mask_q    <= '0;
      resp_type_q   <= '0;
      wb_q          <= 1'b0;
      new_state_q   <= DIR_UNCACHED;
      new_sharers_q <= '0;
      pending_q     <= '0;
      cnt_q         <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (req_valid) begin
            req_type_q <= req_type;
            req_node_q <= req_node;
            req_addr_q <= req_addr;
          end
        end
        S_LOOKUP: begin
          cmd_type_q    <= dec_cmd_type;
          cmd_mask_q    <= dec_mask;
          resp_type_q   <= dec_resp;
          wb_q          <= dec_wb;
          new_state_q   <= dec_state;
          new_sharers_q <= dec_sharers;
        end
        S_CMD: begin
          pending_q <= cmd_mask_q;
          cnt_q     <= '0;
        end
        S_WAIT_ACK: begin
          pending_q <= timeout_hit ? '0 : pending_after;
          cnt_q     <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (fsm_q == S_IDLE);
  assign cmd_valid  = (fsm_q == S_CMD);
  assign cmd_type   = cmd_valid ? cmd_type_q : '0;
  assign cmd_mask   = cmd_valid ? cmd_mask_q : '0;
  assign cmd_addr   = cmd_valid ? req_addr_q : '0;
  assign resp_valid = (fsm_q == S_RESPOND);
  assign resp_type  = resp_valid ? resp_type_q : '0;
  assign resp_node  = resp_valid ? req_node_q : '0;
  assign resp_addr  = resp_valid ? req_addr_q : '0;
  assign mem_wb     = resp_valid && wb_q;
  assign err        = ((fsm_q == S_LOOKUP) && illegal) || timeout_hit;

endmodule

// File: doc/directory_controller.md
Name: directory_controller

Overview:
- Home-node directory for the MSI coherence protocol: one sequential controller serving NUM_NODES caches over NUM_BLOCKS directory entries.
- Each entry holds a directory state plus a sharer bit-vector.
- Accepts one miss/upgrade request at a time, sends invalidate/fetch commands to remote caches, collects per-node acks, then returns a response to the requester.
- Sits between the per-cache MSI controllers and memory.

Parameters:
- NUM_NODES, 4, number of caches; sharer vector width.
- NUM_BLOCKS, 16, number of directory entries.
- ADDR_W, $clog2(NUM_BLOCKS), block index width.
- NODE_W, $clog2(NUM_NODES), node id width.
- ACK_TIMEOUT, 255, maximum cycles spent in WAIT_ACK.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  combinational, equals (fsm==IDLE).
- req_type  in  2  READ_MISS=00, WRITE_MISS=01, UPGRADE=10; 11 is illegal.
- req_node  in  NODE_W  requesting node.
- req_addr  in  ADDR_W  block index.
- cmd_valid  out  1  one-cycle pulse.
- cmd_type  out  2  INV=00, FETCH=01, FETCH_INV=10.
- cmd_mask  out  NUM_NODES  target nodes.
- cmd_addr  out  ADDR_W  block index for the command.
- ack_vec  in  NUM_NODES  per-node one-cycle ack pulses.
- resp_valid  out  1  one-cycle pulse.
- resp_type  out  2  DATA_SHARED=00, DATA_EXCL=01, UPGRADE_ACK=10.
- resp_node  out  NODE_W  destination node.
- resp_addr  out  ADDR_W  block index for the response.
- mem_wb  out  1  pulse; owner data written back to memory.
- err  out  1  pulse; illegal request or ack timeout.

Behaviour:
- Encodings: directory state UNCACHED=2'b01, SHARED=2'b10, EXCLUSIVE=2'b11. In EXCLUSIVE the sharer vector is one-hot and marks the owner.
- Reset (async): FSM goes to IDLE. Every entry becomes UNCACHED with sharers=0. Pending mask and timeout counter clear. All outputs are 0 except req_ready=1.
- FSM states: IDLE -> LOOKUP -> (CMD -> WAIT_ACK ->) RESPOND -> IDLE.
- Handshake:
  - A request is accepted on a clk edge with req_valid && req_ready; req_type/req_node/req_addr are registered on that edge.
  - LOOKUP reads the entry and decides the action.
  - No remote action needed: RESPOND next. If acceptance is at edge T, resp_valid is high in cycle T+2.
  - Remote action needed: CMD drives cmd_valid for one cycle, and pending is loaded with cmd_mask. Then WAIT_ACK.
- WAIT_ACK:
  - Each cycle, pending &= ~ack_vec.
  - Acks on nodes not in pending are ignored. Acks outside WAIT_ACK are ignored.
  - Several acks in the same cycle are all accepted.
  - When pending reaches 0, go to RESPOND on the next edge.
- Entry write and mem_wb:
  - The entry is written on the edge that leaves RESPOND.
  - mem_wb is asserted in the RESPOND cycle when the command was FETCH or FETCH_INV.
- Transitions (r = requester):
  - UNCACHED, READ_MISS: go SHARED, sharers={r}, respond DATA_SHARED.
  - UNCACHED, WRITE_MISS or UPGRADE: go EXCLUSIVE, owner=r, respond DATA_EXCL.
  - SHARED, READ_MISS: sharers|={r}, respond DATA_SHARED.
  - SHARED, WRITE_MISS: send INV to sharers&~{r} (command skipped if empty). Then go EXCLUSIVE, owner=r, respond DATA_EXCL.
  - SHARED, UPGRADE with r in sharers: as WRITE_MISS, but respond UPGRADE_ACK.
  - SHARED, UPGRADE with r not in sharers: handled as WRITE_MISS (stale upgrade).
  - EXCLUSIVE owner o≠r, READ_MISS: FETCH to {o}. Then go SHARED, sharers={o,r}, respond DATA_SHARED with mem_wb.
  - EXCLUSIVE owner o≠r, WRITE_MISS or UPGRADE: FETCH_INV to {o}. Then owner=r, respond DATA_EXCL with mem_wb.
  - EXCLUSIVE, r==owner, READ_MISS: go SHARED, sharers={r}, respond DATA_SHARED directly. The eviction write-back already happened.
  - EXCLUSIVE, r==owner, WRITE_MISS or UPGRADE: no change, respond DATA_EXCL or UPGRADE_ACK directly.
- Illegal req_type=11: the request is accepted. err pulses in the LOOKUP cycle. There is no response and no entry change; return to IDLE.
- Timeout:
  - The counter counts cycles spent in WAIT_ACK.
  - When it reaches ACK_TIMEOUT with pending≠0, err pulses, pending is forced to 0, and the FSM goes to RESPOND with a normal entry update.
- Node id r is assumed < NUM_NODES; ids >= NUM_NODES are undefined behaviour.

Decomposition:
- Package dir_pkg: directory state, req/cmd/resp type enums, and FSM state enum.
- Sub-module directory_entry_array: NUM_BLOCKS x {state[1:0], sharers[NUM_NODES-1:0]} storage.
  - One registered-address read port and one write port.
  - Async reset initialises every entry to UNCACHED with sharers=0.

Test Plan:
- Reset; node1 READ_MISS addr3 accepted at T -> resp_valid at T+2, DATA_SHARED, resp_node=1; entry3 = SHARED, sharers=0010.
- Nodes 0 and 2 READ_MISS addr5; node3 WRITE_MISS addr5 -> cmd INV, mask 0101. Drive ack_vec=0001, then 0100 two cycles later -> DATA_EXCL to node3 one cycle after the last ack; entry5 = EXCLUSIVE, sharers=1000.
- Node2 WRITE_MISS addr7; node0 READ_MISS addr7 -> cmd FETCH, mask 0100; ack -> mem_wb and DATA_SHARED to node0 in the same cycle; entry7 = SHARED, sharers=0101.
- Nodes 1 and 2 share addr9; node1 UPGRADE -> cmd INV, mask 0100; ack -> UPGRADE_ACK to node1; entry9 = EXCLUSIVE, sharers=0010. A later UPGRADE from node1 -> direct UPGRADE_ACK, no cmd.
- ACK_TIMEOUT=8, no acks -> err pulse on the 8th WAIT_ACK cycle, then response issued and req_ready=1. req_type=11 -> err pulse, no resp_valid.
- Assert reset during WAIT_ACK -> all outputs 0 immediately; after release, node0 READ_MISS of the same addr -> direct DATA_SHARED at T+2.
